// File: rtl/fifo_unpack_pkg.sv
// Shared types and elaboration helpers for the FIFO word unpacker.
// Latency: none (package only).
// Backpressure: none (package only).
package fifo_unpack_pkg;

    typedef logic [1:0] occ_t;

    function automatic int ratio_f(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    function automatic int beat_w_f(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic bit width_ok_f(input int in_w, input int out_w);
        return (out_w > 0) && (in_w >= out_w) && ((in_w % out_w) == 0);
    endfunction

endpackage

// File: rtl/fifo_unpack_buf.sv
// Two-slot word holder: cur is the word being sliced, pre is the prefetched next word.
// Latency: a loaded word is visible in cur/pre the cycle after load.
// Backpressure: none internally; the caller never loads when both slots and the in-flight read are taken.
module fifo_unpack_buf
    import fifo_unpack_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_word,
    input  logic         retire,
    output logic         cur_vld,
    output logic [W-1:0] cur_word,
    output logic         pre_vld
);

    logic [W-1:0] pre_word;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_vld <= 1'b0;
            pre_vld <= 1'b0;
        end else if (retire) begin
            // Retiring word is replaced by the oldest waiting word: pre first, then the landing read.
            if (pre_vld) begin
                cur_word <= pre_word;
                cur_vld  <= 1'b1;
                pre_vld  <= load;
                if (load) begin
                    pre_word <= load_word;
                end
            end else if (load) begin
                cur_word <= load_word;
            end else begin
                cur_vld <= 1'b0;
            end
        end else if (load) begin
            if (!cur_vld) begin
                cur_word <= load_word;
                cur_vld  <= 1'b1;
            end else begin
                pre_word <= load_word;
                pre_vld  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_unpacker.sv
// Drains IN_W words from a sync FIFO and emits RATIO OUT_W beats each; FIFO_UNPACKER_MSB_FIRST_EN selects MSB-slice-first order.
// Latency: pop in cycle N gives first beat valid in cycle N+2; back-to-back beats across word boundaries.
// Backpressure: out_ready low freezes the current beat; at most two words held, pops stop once occupancy reaches two.
module fifo_unpacker
    import fifo_unpack_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             fifo_empty,
    output logic             fifo_pop,
    input  logic [IN_W-1:0]  fifo_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int RATIO  = ratio_f(IN_W, OUT_W);
    localparam int BEAT_W = beat_w_f(RATIO);

    generate
        if (!width_ok_f(IN_W, OUT_W)) begin : g_bad_width
            $error("fifo_unpacker: IN_W must be a positive integer multiple of OUT_W");
        end
    endgenerate

    logic                        inflight;
    logic [BEAT_W-1:0]           beat_cnt;
    logic [BEAT_W-1:0]           slice_idx;
    logic                        cur_vld;
    logic                        pre_vld;
    logic [IN_W-1:0]             cur_word;
    logic [RATIO-1:0][OUT_W-1:0] slices;
    occ_t                        occ;
    logic                        last_beat;
    logic                        beat_acc;
    logic                        word_done;

    fifo_unpack_buf #(
        .W (IN_W)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (inflight),
        .load_word (fifo_data),
        .retire    (word_done),
        .cur_vld   (cur_vld),
        .cur_word  (cur_word),
        .pre_vld   (pre_vld)
    );

    assign occ       = occ_t'(cur_vld) + occ_t'(pre_vld) + occ_t'(inflight);
    assign last_beat = (beat_cnt == BEAT_W'(RATIO - 1));
    assign beat_acc  = cur_vld & out_ready;
    assign word_done = beat_acc & last_beat;

    // A retiring word frees a slot in the same cycle, so a full buffer may still pop.
    assign fifo_pop  = reset_n & ~fifo_empty & ((occ < 2'd2) | word_done);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inflight <= 1'b0;
            beat_cnt <= '0;
        end else begin
            inflight <= fifo_pop;
            if (beat_acc) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
            end
        end
    end

`ifdef FIFO_UNPACKER_MSB_FIRST_EN
    assign slice_idx = BEAT_W'(RATIO - 1) - beat_cnt;
`else
    assign slice_idx = beat_cnt;
`endif

    assign slices    = cur_word;
    assign out_data  = slices[slice_idx];
    assign out_valid = cur_vld;
    assign out_last  = cur_vld & last_beat;
    assign busy      = (occ != 2'd0);

endmodule
